bcd_updown_timer: RTL and testbench
===================================

Name: bcd_updown_timer

Overview:
- Parametrised successor to the fixed 4-digit start/progressive/regressive counter top.
- Multi-digit BCD up/down timer with a run-time limit, pause/resume, a stop-or-wrap end mode and a time-multiplexed common-anode 7-segment driver.
- Takes already-debounced single-cycle command pulses from the board debouncer.
- Drives the display pins and a finish flag directly.

Parameters:
- DIGITS, 4: number of BCD digits and anodes (1..8).
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 1: count rate.
- SCAN_HZ, 1000: per-digit display refresh rate.
- WRAP, 0: 0 = stop at the end bound; 1 = reload and continue.

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_up  in  1  pulse: load 0, count up.
- start_down  in  1  pulse: load limit, count down.
- pause  in  1  pulse: toggle run/pause.
- clear  in  1  pulse: return to IDLE with count 0.
- limit_bcd  in  4*DIGITS  end/start value, one BCD nibble per digit, LS nibble = digit 0.
- count_bcd  out  4*DIGITS  current count.
- seg  out  7  {g..a}, active-low.
- dp  out  1  active-low decimal point.
- an  out  DIGITS  active-low one-hot anode enables.
- running  out  1  high in RUN_UP or RUN_DOWN.
- finish  out  1  end-bound indication.

Behaviour:
- Interface: one clock, clk_100MHz; reset_n is asynchronous and active-low.
- Reset values: state IDLE, count_bcd 0, prescaler 0, scan index 0, an = ~1 (digit 0 enabled), seg = digit-0 pattern for 0, dp 1, running 0, finish 0.
- States: IDLE, RUN_UP, RUN_DOWN, PAUSED, DONE.
  - PAUSED remembers the direction in a dir register.
- Command priority within a cycle: clear > start_up > start_down > pause.
  - Lower-priority commands in the same cycle are ignored.
- clear from any state:
  - Go to IDLE; count 0; finish 0; prescaler 0.
- start_up from any state:
  - Latch the limit (see below); count 0; prescaler 0; go to RUN_UP; finish 0.
- start_down from any state:
  - Latch the limit; count = latched limit; prescaler 0; go to RUN_DOWN; finish 0.
- Limit latching: limit_bcd is sampled only on a start. Any nibble > 9 is clamped to 9.
- pause:
  - RUN_x -> PAUSED.
  - PAUSED -> RUN_dir.
  - Ignored in IDLE and DONE.
  - The prescaler holds its value while PAUSED.
- Tick: the prescaler counts 0..CLK_HZ/TICK_HZ-1 while running. One tick cycle occurs at the terminal value, then it returns to 0.
- Stepping on a tick: the count changes by ±1 in BCD with digit-ripple carry/borrow, so there is no binary intermediate.
  - The new value is visible on count_bcd the cycle after the tick.
- Up end bound: a tick with count == latched limit.
  - WRAP=0: count holds; go to DONE; finish = 1 (level) until clear or start.
  - WRAP=1: count <- 0; stay in RUN_UP; finish high for exactly that one cycle.
- Down end bound: a tick with count == 0.
  - WRAP=0: DONE.
  - WRAP=1: count <- latched limit; one-cycle finish.
- Limit 0:
  - start_up: the first tick hits the bound immediately.
  - start_down: same behaviour as start_up.
- Count hold: count_bcd holds its value in PAUSED, DONE and IDLE.
- running: combinational decode of the state (registered-state based).
- Display scan: a scan counter counts 0..CLK_HZ/(SCAN_HZ)-1 and then advances the scan index modulo DIGITS. The scan runs in every state, including IDLE.
  - an[i] = 0 only for the selected digit.
  - seg is the registered decode of the selected nibble.
  - an and seg update in the same cycle, with no ghost cycle.
- dp: 0 on digit 0 while PAUSED; 1 otherwise.
- Reset asserted mid-count: everything returns to reset values immediately and asynchronously. There is no resume.

Decomposition:
- Package bcd_timer_pkg holds:
  - the state enum;
  - the 7-segment active-low patterns for 0-9, plus a blank pattern for invalid values;
  - the function for BCD increment/decrement of one nibble with carry/borrow.
- Sub-module seg7_decoder: a 4-bit BCD input gives a 7-bit active-low output.
  - Instantiated once after the scan mux.

Test Plan (CLK_HZ=10, TICK_HZ=1, SCAN_HZ=5, DIGITS=4 unless stated):
- Reset: hold reset_n=0 with random inputs. Expect count_bcd=0, an=4'b1110, seg=7'b1000000, dp=1, finish=0, running=0. Release; no change until a command arrives.
- Up, stop mode (WRAP=0): limit=0x0012, start_up. Expect count 0x0001 after 10 cycles, with ripple 0x0009->0x0010 seen. Count reaches 0x0012; next tick gives DONE with finish=1 held and count held at 0x0012.
- Down, wrap mode (WRAP=1): limit=0x0100, start_down. Expect count 0x0100 -> 0x0099 (borrow) -> ... -> 0x0000. On the next tick count=0x0100 and finish is a 1-cycle pulse; running stays 1.
- Pause: pause at prescaler=4. Hold 50 cycles; expect count frozen, dp=0 while an=1110, running=0. Resume; expect the next tick after 6 cycles.
- Priority: clear+start_up in the same cycle gives IDLE. start_up+start_down gives RUN_UP from 0. Limit 0xA5F3 latched on start is clamped to 0x9593.
- Scan: with count=0x1234, expect an to cycle 1110, 1101, 1011, 0111 every 2 cycles, with seg showing 4, 3, 2, 1 in lockstep.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types, 7-segment patterns and BCD helpers for the up/down timer.
package bcd_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_UP,
    ST_RUN_DOWN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       co;
    logic [3:0] d;
  } nib_step_t;

  // One BCD digit of a ripple increment/decrement; ci=0 passes the digit through.
  function automatic nib_step_t bcd_nibble_step(input logic [3:0] d,
                                                input logic       down,
                                                input logic       ci);
    nib_step_t r;
    r.co = 1'b0;
    r.d  = d;
    if (ci) begin
      if (!down) begin
        if (d >= 4'd9) begin
          r.d  = 4'd0;
          r.co = 1'b1;
        end else begin
          r.d = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          r.d  = 4'd9;
          r.co = 1'b1;
        end else begin
          r.d = d - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_updown_timer_seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module seg7_decoder
  import bcd_timer_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_DIGIT[0];
      4'd1:    seg_o = SEG_DIGIT[1];
      4'd2:    seg_o = SEG_DIGIT[2];
      4'd3:    seg_o = SEG_DIGIT[3];
      4'd4:    seg_o = SEG_DIGIT[4];
      4'd5:    seg_o = SEG_DIGIT[5];
      4'd6:    seg_o = SEG_DIGIT[6];
      4'd7:    seg_o = SEG_DIGIT[7];
      4'd8:    seg_o = SEG_DIGIT[8];
      4'd9:    seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// Multi-digit BCD up/down timer with limit, pause, stop/wrap end mode and
// a multiplexed common-anode 7-segment display driver.
module bcd_updown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned WRAP    = 0
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  start_up,
  input  logic                  start_down,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   limit_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  running,
  output logic                  finish
);

  localparam int unsigned CW       = 4 * DIGITS;
  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   limit_q, limit_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            finish_q, finish_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic [6:0]      seg_q, seg_d;

  logic [CW-1:0]   limit_clamped;
  logic [CW-1:0]   count_stepped;
  logic [3:0]      sel_nib;
  logic            run_down;
  logic            tick;
  logic            at_bound;
  logic            wrap_hit;

  assign running  = (state_q == ST_RUN_UP) || (state_q == ST_RUN_DOWN);
  assign run_down = (state_q == ST_RUN_DOWN);
  assign tick     = running && (presc_q == TICK_LAST);
  assign at_bound = run_down ? (count_q == '0) : (count_q == limit_q);

  // Digit-serial BCD step: carry/borrow ripples from digit 0 upward, so the
  // count never passes through a binary intermediate.
  always_comb begin
    nib_step_t st;
    logic      carry;
    st            = '0;
    carry         = 1'b1;
    limit_clamped = '0;
    count_stepped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      limit_clamped[4*i +: 4] = bcd_clamp(limit_bcd[4*i +: 4]);
      st                      = bcd_nibble_step(count_q[4*i +: 4], run_down, carry);
      count_stepped[4*i +: 4] = st.d;
      carry                   = st.co;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    count_d  = count_q;
    limit_d  = limit_q;
    presc_d  = presc_q;
    wrap_hit = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (start_up) begin
      state_d = ST_RUN_UP;
      dir_d   = 1'b0;
      limit_d = limit_clamped;
      count_d = '0;
      presc_d = '0;
    end else if (start_down) begin
      state_d = ST_RUN_DOWN;
      dir_d   = 1'b1;
      limit_d = limit_clamped;
      count_d = limit_clamped;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_RUN_UP, ST_RUN_DOWN: begin
          // A pause landing on the terminal prescaler value defers that tick
          // to the first cycle after resume rather than dropping it.
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            presc_d = '0;
            if (at_bound) begin
              if (WRAP != 0) begin
                count_d  = run_down ? limit_q : '0;
                wrap_hit = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_stepped;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            state_d = dir_q ? ST_RUN_DOWN : ST_RUN_UP;
          end
        end
        default: ;
      endcase
    end

    finish_d = (state_d == ST_DONE) || wrap_hit;
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  // Decode from next-cycle index/count so the registered segments line up
  // with the anode decode of the registered index.
  always_comb begin
    sel_nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_idx_d == IW'(i)) begin
        sel_nib = count_d[4*i +: 4];
      end
    end
  end

  seg7_decoder u_seg7_decoder (
    .bcd_i (sel_nib),
    .seg_o (seg_d)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      count_q    <= '0;
      limit_q    <= '0;
      presc_q    <= '0;
      finish_q   <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_DIGIT[0];
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      presc_q    <= presc_d;
      finish_q   <= finish_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    an = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        an[i] = 1'b0;
      end
    end
  end

  assign dp        = !((state_q == ST_PAUSED) && (scan_idx_q == '0));
  assign count_bcd = count_q;
  assign seg       = seg_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Bench for bcd_updown_timer: stop-mode and wrap-mode instances share stimulus
// and are compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_updown_timer;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DOWN  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 2;
  localparam int NDIG     = 4;

  localparam logic [6:0] SEGTAB [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        start_up = 1'b0;
  logic        start_down = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] limit_bcd = '0;

  logic [15:0] cnt_o [2];
  logic [6:0]  seg_o [2];
  logic        dp_o  [2];
  logic [3:0]  an_o  [2];
  logic        run_o [2];
  logic        fin_o [2];

  always #5 clk = ~clk;

  bcd_updown_timer #(.DIGITS(4), .CLK_HZ(10), .TICK_HZ(1), .SCAN_HZ(5), .WRAP(0)) u_stop (
    .clk_100MHz (clk),      .reset_n (reset_n),
    .start_up   (start_up), .start_down (start_down),
    .pause      (pause),    .clear (clear),
    .limit_bcd  (limit_bcd),
    .count_bcd  (cnt_o[0]), .seg (seg_o[0]), .dp (dp_o[0]), .an (an_o[0]),
    .running    (run_o[0]), .finish (fin_o[0])
  );

  bcd_updown_timer #(.DIGITS(4), .CLK_HZ(10), .TICK_HZ(1), .SCAN_HZ(5), .WRAP(1)) u_wrap (
    .clk_100MHz (clk),      .reset_n (reset_n),
    .start_up   (start_up), .start_down (start_down),
    .pause      (pause),    .clear (clear),
    .limit_bcd  (limit_bcd),
    .count_bcd  (cnt_o[1]), .seg (seg_o[1]), .dp (dp_o[1]), .an (an_o[1]),
    .running    (run_o[1]), .finish (fin_o[1])
  );

  int n_total = 0;
  int n_pass  = 0;

  int m_mode [2];
  int m_saved[2];
  int m_cnt  [2];
  int m_lim  [2];
  int m_presc[2];
  int m_fin  [2];
  int m_sc   [2];
  int m_idx  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int lim_dec(input logic [15:0] l);
    int v = 0;
    int mul = 1;
    for (int i = 0; i < NDIG; i++) begin
      int nib = int'((l >> (4*i)) & 16'h000F);
      if (nib > 9) nib = 9;
      v += nib * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r |= 16'(v % 10) << (4*i);
      v /= 10;
    end
    return r;
  endfunction

  function automatic int digit_of(input int v, input int idx);
    for (int i = 0; i < idx; i++) v /= 10;
    return v % 10;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_saved[k] = M_UP; m_cnt[k] = 0; m_lim[k] = 0;
      m_presc[k] = 0; m_fin[k] = 0; m_sc[k] = 0; m_idx[k] = 0;
    end
  endtask

  task automatic model_adv();
    for (int k = 0; k < 2; k++) begin
      bit pulse;
      pulse = 1'b0;
      if (clear) begin
        m_mode[k] = M_IDLE; m_cnt[k] = 0; m_presc[k] = 0;
      end else if (start_up) begin
        m_lim[k] = lim_dec(limit_bcd); m_cnt[k] = 0; m_presc[k] = 0; m_mode[k] = M_UP;
      end else if (start_down) begin
        m_lim[k] = lim_dec(limit_bcd); m_cnt[k] = m_lim[k]; m_presc[k] = 0; m_mode[k] = M_DOWN;
      end else if (m_mode[k] == M_UP || m_mode[k] == M_DOWN) begin
        if (pause) begin
          m_saved[k] = m_mode[k];
          m_mode[k]  = M_PAUSE;
        end else if (m_presc[k] == TICK_DIV - 1) begin
          m_presc[k] = 0;
          if (m_mode[k] == M_UP) begin
            if (m_cnt[k] == m_lim[k]) begin
              if (k == 1) begin m_cnt[k] = 0; pulse = 1'b1; end
              else m_mode[k] = M_DONE;
            end else m_cnt[k]++;
          end else begin
            if (m_cnt[k] == 0) begin
              if (k == 1) begin m_cnt[k] = m_lim[k]; pulse = 1'b1; end
              else m_mode[k] = M_DONE;
            end else m_cnt[k]--;
          end
        end else begin
          m_presc[k]++;
        end
      end else if (m_mode[k] == M_PAUSE && pause) begin
        m_mode[k] = m_saved[k];
      end
      m_fin[k] = (m_mode[k] == M_DONE || pulse) ? 1 : 0;
      if (m_sc[k] == SCAN_DIV - 1) begin
        m_sc[k]  = 0;
        m_idx[k] = (m_idx[k] + 1) % NDIG;
      end else begin
        m_sc[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("w%0d.count", k), 32'(cnt_o[k]), 32'(to_bcd(m_cnt[k])));
      check($sformatf("w%0d.running", k), 32'(run_o[k]),
            32'((m_mode[k] == M_UP || m_mode[k] == M_DOWN) ? 1 : 0));
      check($sformatf("w%0d.finish", k), 32'(fin_o[k]), 32'(m_fin[k]));
      check($sformatf("w%0d.an", k), 32'(an_o[k]), 32'(4'hF & ~(4'b0001 << m_idx[k])));
      check($sformatf("w%0d.seg", k), 32'(seg_o[k]), 32'(SEGTAB[digit_of(m_cnt[k], m_idx[k])]));
      check($sformatf("w%0d.dp", k), 32'(dp_o[k]),
            32'((m_mode[k] == M_PAUSE && m_idx[k] == 0) ? 0 : 1));
    end
  endtask

  // One clock: drive at a falling edge, advance model, compare at next falling edge.
  task automatic cyc(input logic c, input logic su, input logic sd, input logic pz,
                     input logic [15:0] lim);
    clear = c; start_up = su; start_down = sd; pause = pz; limit_bcd = lim;
    if (reset_n) model_adv();
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, limit_bcd);
  endtask

  function automatic logic [15:0] rand_limit();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {12'h000, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    model_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 16'($urandom));
    reset_n = 1'b1;
    idle(6);

    // Up count to 12 in stop mode, ripple 09->10 along the way
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0012);
    idle(10);
    check("up.first_tick", 32'(cnt_o[0]), 32'h0001);
    idle(125);
    check("up.done_count", 32'(cnt_o[0]), 32'h0012);
    check("up.done_finish", 32'(fin_o[0]), 32'h1);

    // Down from 100 in wrap mode, through the 100->99 borrow and the reload
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
    check("down.load", 32'(cnt_o[1]), 32'h0100);
    idle(1015);

    // Pause at prescaler 4, hold, resume: next tick 6 cycles later
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
    idle(50);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
    idle(5);
    check("pause.before_tick", 32'(cnt_o[0]), 32'h0000);
    idle(1);
    check("pause.after_tick", 32'(cnt_o[0]), 32'h0001);

    // Command priority and limit clamping
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    check("prio.clear_wins", 32'(run_o[0]), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0005);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'hA5F3);
    check("prio.clamp", 32'(cnt_o[0]), 32'h9593);
    idle(20);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(3);

    // Display scan over a frozen 1234
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    idle(16);

    // Limit zero in both directions
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(25);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle(25);

    // Random command pulses, with one asynchronous reset mid-run
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom));
        reset_n = 1'b1;
      end
      cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) == 0),
          1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 49) == 0), rand_limit());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
